// File: rtl/step_sequencer.sv
// step_sequencer: programmable valve/delay step sequencer feeding the delay counter.
// Each program entry is {last, unit[2:0], delay[5:0], valves[VALVES-1:0]}.
// Optional feature: define SEQ_LOOP_EN to add a loop_cnt input that replays the program.
module step_sequencer #(
    parameter int unsigned VALVES = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [VALVES+9:0] prog_wdata,
    input  logic              run,
    input  logic              abort,
`ifdef SEQ_LOOP_EN
    input  logic [7:0]        loop_cnt,
`endif
    input  logic              count_done,
    output logic [5:0]        delay,
    output logic [2:0]        delay_unit,
    output logic              delay_start,
    output logic [VALVES-1:0] valve_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AW-1:0]     step_idx
);

    localparam int unsigned EW       = VALVES + 10;
    localparam int unsigned MAX_UNIT = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ARM, S_WAIT, S_REL, S_FIN, S_ERR
    } state_t;

    state_t            state, state_d;
    logic [EW-1:0]     mem [DEPTH];
    logic [EW-1:0]     entry;
    logic [VALVES-1:0] e_valves;
    logic [5:0]        e_delay;
    logic [2:0]        e_unit;
    logic              e_last;
    logic              last_q, last_d;
    logic              end_of_pass;
    logic              active;

    logic [5:0]        delay_d;
    logic [2:0]        delay_unit_d;
    logic              delay_start_d;
    logic [VALVES-1:0] valve_out_d;
    logic              busy_d;
    logic              done_d;
    logic              err_d;
    logic [AW-1:0]     step_idx_d;

`ifdef SEQ_LOOP_EN
    logic [7:0]        loops_q, loops_d;
`endif

    // Program RAM: not reset, frozen while a sequence is running.
    always_ff @(posedge clk) begin
        if (prog_we && !busy && (32'(prog_addr) < DEPTH)) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    assign entry       = mem[step_idx];
    assign e_valves    = entry[VALVES-1:0];
    assign e_delay     = entry[VALVES+5:VALVES];
    assign e_unit      = entry[VALVES+8:VALVES+6];
    assign e_last      = entry[VALVES+9];
    assign end_of_pass = last_q || (step_idx == AW'(DEPTH - 1));
    assign active      = (state == S_FETCH) || (state == S_ARM) || (state == S_WAIT) ||
                         (state == S_REL)   || (state == S_FIN);

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            delay       <= '0;
            delay_unit  <= '0;
            delay_start <= 1'b0;
            valve_out   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            step_idx    <= '0;
            last_q      <= 1'b0;
`ifdef SEQ_LOOP_EN
            loops_q     <= '0;
`endif
        end else begin
            state       <= state_d;
            delay       <= delay_d;
            delay_unit  <= delay_unit_d;
            delay_start <= delay_start_d;
            valve_out   <= valve_out_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            step_idx    <= step_idx_d;
            last_q      <= last_d;
`ifdef SEQ_LOOP_EN
            loops_q     <= loops_d;
`endif
        end
    end

    // Next state and next output values; abort overrides everything while active.
    always_comb begin
        state_d       = state;
        delay_d       = delay;
        delay_unit_d  = delay_unit;
        delay_start_d = delay_start;
        valve_out_d   = valve_out;
        busy_d        = busy;
        done_d        = 1'b0;
        err_d         = err;
        step_idx_d    = step_idx;
        last_d        = last_q;
`ifdef SEQ_LOOP_EN
        loops_d       = loops_q;
`endif

        case (state)
            S_IDLE, S_ERR: begin
                if (run) begin
                    step_idx_d = '0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_FETCH;
`ifdef SEQ_LOOP_EN
                    loops_d    = loop_cnt;
`endif
                end
            end
            S_FETCH: begin
                valve_out_d  = e_valves;
                delay_d      = e_delay;
                delay_unit_d = e_unit;
                last_d       = e_last;
                if (e_unit > 3'(MAX_UNIT)) begin
                    err_d       = 1'b1;
                    valve_out_d = '0;
                    busy_d      = 1'b0;
                    state_d     = S_ERR;
                end else if (e_delay == 6'd0) begin
                    state_d = S_REL;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                delay_start_d = 1'b1;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                if (count_done) begin
                    delay_start_d = 1'b0;
                    state_d       = S_REL;
                end
            end
            S_REL: begin
                if (end_of_pass) begin
`ifdef SEQ_LOOP_EN
                    if (loops_q != 8'd0) begin
                        loops_d    = loops_q - 8'd1;
                        step_idx_d = '0;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_FIN;
                    end
`else
                    state_d = S_FIN;
`endif
                end else begin
                    step_idx_d = step_idx + AW'(1);
                    state_d    = S_FETCH;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && active) begin
            delay_start_d = 1'b0;
            valve_out_d   = '0;
            busy_d        = 1'b0;
            done_d        = 1'b0;
            state_d       = S_IDLE;
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed scenarios plus randomized programs checked
// against a program-level reference walk. Loop tests run when SEQ_LOOP_EN is defined.
module tb_step_sequencer;

    localparam int unsigned VALVES = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AW     = 4;

    logic              clk = 1'b0;
    logic              rst, prog_we, run, abort, count_done;
    logic [AW-1:0]     prog_addr;
    logic [VALVES+9:0] prog_wdata;
    logic [7:0]        loop_cnt;
    logic [5:0]        delay;
    logic [2:0]        delay_unit;
    logic              delay_start, busy, done, err;
    logic [VALVES-1:0] valve_out;
    logic [AW-1:0]     step_idx;

    step_sequencer #(.VALVES(VALVES), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .run(run), .abort(abort),
`ifdef SEQ_LOOP_EN
        .loop_cnt(loop_cnt),
`endif
        .count_done(count_done), .delay(delay), .delay_unit(delay_unit),
        .delay_start(delay_start), .valve_out(valve_out), .busy(busy),
        .done(done), .err(err), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pack(input logic [3:0] idx, input logic [2:0] u,
                                input logic [5:0] d, input logic [7:0] v);
        return int'({11'd0, idx, u, d, v});
    endfunction

    function automatic logic [17:0] mk(input logic last, input logic [2:0] u,
                                       input logic [5:0] d, input logic [7:0] v);
        return {last, u, d, v};
    endfunction

    // Delay-counter stand-in: raises count_done a random number of cycles after
    // delay_start, holds it until delay_start drops; manual mode for directed cases.
    bit   cd_auto   = 1'b1;
    logic cd_manual = 1'b0;
    int   cd_cnt    = 0;
    int   cd_lat    = 0;
    initial begin
        count_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!cd_auto) begin
                count_done = cd_manual;
            end else if (delay_start !== 1'b1) begin
                count_done = 1'b0;
                cd_cnt     = 0;
                cd_lat     = int'($urandom_range(0, 3));
            end else if (!count_done) begin
                if (cd_cnt >= cd_lat) count_done = 1'b1;
                else cd_cnt++;
            end
        end
    end

    // Observer: logs each armed step and the cycle of each delay_start/count_done rise.
    int   rec_q[$];
    int   rise_t[$];
    int   cd_t[$];
    int   done_cnt = 0;
    logic prev_ds  = 1'b0;
    logic prev_cd  = 1'b0;
    initial begin
        forever begin
            @(negedge clk); #2;
            if (delay_start === 1'b1 && !prev_ds) begin
                rec_q.push_back(pack(step_idx, delay_unit, delay, valve_out));
                rise_t.push_back(cyc);
            end
            if (count_done === 1'b1 && !prev_cd) cd_t.push_back(cyc);
            if (done === 1'b1) done_cnt++;
            prev_ds = (delay_start === 1'b1);
            prev_cd = (count_done === 1'b1);
        end
    end

    // Reference: walk the program by its rules, listing steps that arm the counter.
    logic [17:0] prog [DEPTH];
    int exp_q[$];
    int exp_done, exp_err, exp_valves, exp_idx;

    task automatic model(input int loops);
        int idx;
        int left;
        logic [17:0] e;
        idx = 0; left = loops;
        exp_q.delete();
        exp_done = 0; exp_err = 0; exp_valves = 0; exp_idx = 0;
        for (int n = 0; n < int'(DEPTH) * (loops + 1); n++) begin
            e = prog[idx];
            exp_idx = idx;
            if (e[16:14] > 3'd4) begin
                exp_err = 1; exp_valves = 0;
                return;
            end
            if (e[13:8] != 6'd0) exp_q.push_back(pack(4'(idx), e[16:14], e[13:8], e[7:0]));
            exp_valves = int'(e[7:0]);
            if (e[17] || idx == int'(DEPTH) - 1) begin
                if (left > 0) begin
                    left--; idx = 0;
                end else begin
                    exp_done = 1;
                    return;
                end
            end else begin
                idx++;
            end
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < int'(DEPTH); i++) begin
            prog_we = 1'b1; prog_addr = 4'(i); prog_wdata = prog[i];
            @(posedge clk); #1;
        end
        prog_we = 1'b0;
    endtask

    int done_base = 0;

    task automatic run_seq(input bit inject, output int run_t);
        bit fin;
        rec_q.delete(); rise_t.delete(); cd_t.delete();
        done_base = done_cnt;
        run = 1'b1; run_t = cyc;
        @(posedge clk); #1;
        run = 1'b0;
        check("run_busy", busy, 1);
        check("run_err_clr", err, 0);
        if (inject) begin
            repeat (4) @(posedge clk); #1;
            run = 1'b1; prog_we = 1'b1; prog_addr = 4'd2; prog_wdata = mk(1, 0, 9, 8'hAA);
            @(posedge clk); #1;
            run = 1'b0; prog_we = 1'b0;
        end
        fin = 1'b0;
        for (int i = 0; i < 4000 && !fin; i++) begin
            @(negedge clk); #3;
            if (busy === 1'b0) fin = 1'b1;
        end
        check("run_timeout", fin, 1);
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic check_results(input string tag);
        check({tag, "_nsteps"}, rec_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++)
            check({tag, "_step"}, rec_q[i], exp_q[i]);
        check({tag, "_done"}, done_cnt - done_base, exp_done);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_valves"}, valve_out, exp_valves);
        check({tag, "_idx"}, step_idx, exp_idx);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ds"}, delay_start, 0);
    endtask

    function automatic int loops_for(input logic [7:0] lc);
`ifdef SEQ_LOOP_EN
        return int'(lc);
`else
        return 0 * int'(lc);
`endif
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rt;
        bit  seen;
        int  dbase;
        rst = 1'b0; prog_we = 1'b0; run = 1'b0; abort = 1'b0;
        prog_addr = '0; prog_wdata = '0; loop_cnt = 8'd0;
        #2 rst = 1'b1;
        #1;
        check("rst_delay", delay, 0);
        check("rst_unit", delay_unit, 0);
        check("rst_ds", delay_start, 0);
        check("rst_valves", valve_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_idx", step_idx, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Three-step program with a mid-run write and run that must be ignored.
        for (int i = 0; i < int'(DEPTH); i++) prog[i] = mk(0, 0, 1, 8'h00);
        prog[0] = mk(0, 0, 5, 8'h01);
        prog[1] = mk(0, 1, 2, 8'h02);
        prog[2] = mk(1, 0, 1, 8'h04);
        load_prog();
        model(0);
        run_seq(1'b1, rt);
        check_results("three");
        check("lat_run", rise_t[0] - rt, 3);
        check("lat_step1", rise_t[1] - cd_t[0], 4);
        check("lat_step2", rise_t[2] - cd_t[1], 4);

        // Invalid unit at index 1, then recovery.
        prog[1] = mk(0, 5, 2, 8'h02);
        load_prog();
        model(0);
        run_seq(1'b0, rt);
        check_results("err");
        check("err_flag", err, 1);
        prog[1] = mk(0, 1, 2, 8'h02);
        load_prog();
        model(0);
        run_seq(1'b0, rt);
        check_results("err_recover");

        // Zero-delay middle step: never arms the counter, costs 2 extra cycles.
        prog[0] = mk(0, 0, 3, 8'h01);
        prog[1] = mk(0, 0, 0, 8'h02);
        prog[2] = mk(1, 0, 2, 8'h04);
        load_prog();
        model(0);
        run_seq(1'b0, rt);
        check_results("zero");
        check("lat_zero", rise_t[1] - cd_t[0], 6);

        // Abort coinciding with count_done.
        cd_auto = 1'b0; cd_manual = 1'b0;
        prog[0] = mk(0, 0, 5, 8'h01);
        prog[1] = mk(1, 0, 3, 8'h02);
        load_prog();
        dbase = done_cnt;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk); #3;
            if (delay_start === 1'b1) seen = 1'b1;
        end
        check("abort_armed", seen, 1);
        @(posedge clk); #1;
        repeat (2) @(posedge clk); #1;
        abort = 1'b1; cd_manual = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; cd_manual = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ds", delay_start, 0);
        check("abort_valves", valve_out, 0);
        repeat (5) @(posedge clk); #1;
        check("abort_ds_hold", delay_start, 0);
        check("abort_no_done", done_cnt - dbase, 0);
        cd_auto = 1'b1;

        // No last flag anywhere: runs through the whole table.
        for (int i = 0; i < int'(DEPTH); i++)
            prog[i] = mk(0, 3'($urandom_range(0, 4)), 6'($urandom_range(1, 3)), 8'($urandom));
        load_prog();
        model(0);
        run_seq(1'b0, rt);
        check_results("full");
        check("full_count", rec_q.size(), DEPTH);

`ifdef SEQ_LOOP_EN
        // Two-step program replayed twice more.
        prog[0] = mk(0, 0, 2, 8'h11);
        prog[1] = mk(1, 2, 3, 8'h22);
        load_prog();
        loop_cnt = 8'd2;
        model(2);
        run_seq(1'b0, rt);
        check_results("loop");
        check("loop_count", rec_q.size(), 6);
`endif

        // Randomized programs.
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                prog[i] = mk(($urandom_range(0, 5) == 0), 3'($urandom_range(0, 4)),
                             ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 7)),
                             8'($urandom));
                if ($urandom_range(0, 14) == 0) prog[i][16:14] = 3'($urandom_range(5, 7));
            end
            load_prog();
            loop_cnt = 8'($urandom_range(0, 2));
            model(loops_for(loop_cnt));
            run_seq(1'b0, rt);
            check_results("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
